// File: rtl/prbs_test_ctrl.sv
// prbs_test_ctrl
// ---------------------------------------------------------------------------
// Runs one PRBS loopback test around an external prbs_gen instance. It holds
// the generator in reset, primes it for one cycle, then forwards num_words
// generator words as transmit data. A LAT-deep copy of the transmitted words
// is compared against the looped-back receive data, and the block keeps
// saturating counts of bit errors and word errors.
//
// Ports
//   clk        clock
//   reset_n    synchronous active-low reset
//   start      one-cycle pulse, begins a test when idle or done
//   abort      one-cycle pulse, terminates a test in progress
//   num_words  number of words to transmit, sampled on an accepted start
//   gen_data   prbs_gen output word
//   gen_rst    prbs_gen reset (active-high)
//   tx_data    word toward the loopback path (zero when tx_valid is low)
//   tx_valid   tx_data carries a test word
//   rx_data    looped-back data, LAT cycles behind tx_data
//   busy       test in progress
//   done       test completed normally
//   aborted    last test was ended by abort
//   bit_errs   saturating count of mismatched bits
//   word_errs  saturating count of words with at least one mismatched bit
// ---------------------------------------------------------------------------
module prbs_test_ctrl #(
  parameter int SIZE       = 8,
  parameter int RST_CYCLES = 4,
  parameter int LAT        = 2,
  parameter int CW         = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   num_words,
  input  logic [SIZE-1:0] gen_data,
  output logic            gen_rst,
  output logic [SIZE-1:0] tx_data,
  output logic            tx_valid,
  input  logic [SIZE-1:0] rx_data,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [CW-1:0]   bit_errs,
  output logic [CW-1:0]   word_errs
);

  // Popcount width, and a sum width wide enough that an addition can never
  // wrap before it is compared against the saturation limit.
  localparam int PW = $clog2(SIZE + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GEN_RST = 3'd1,
    S_PRIME   = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [PW-1:0] popcount(input logic [SIZE-1:0] v);
    logic [PW-1:0] c;
    c = {PW{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  state_t          state_r;
  logic [CW-1:0]   words_r;   // latched word count of the current test
  logic [CW-1:0]   cnt_r;     // down-counter for the timed states
  logic            start_ok_s;
  logic            abort_ok_s;

  logic [LAT-1:0]  dv_r;
  logic [SIZE-1:0] dd_r [LAT];
  logic            exp_valid_s;
  logic [SIZE-1:0] exp_data_s;

  logic [SIZE-1:0] diff_s;
  logic [SW-1:0]   bit_sum_s;
  logic [SW-1:0]   word_sum_s;
  logic [CW-1:0]   bit_next_s;
  logic [CW-1:0]   word_next_s;

  // busy is high exactly in the non-idle, non-done states, so it qualifies
  // which of start and abort may take effect (abort wins while busy).
  assign start_ok_s = start & ~busy;
  assign abort_ok_s = abort & busy;

  // Generator words pass straight through while transmitting.
  assign tx_data = tx_valid ? gen_data : {SIZE{1'b0}};

  // Test sequencer with registered status and control outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      words_r  <= CNT_ZERO;
      cnt_r    <= CNT_ZERO;
      gen_rst  <= 1'b1;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else if (abort_ok_s) begin
      state_r  <= S_IDLE;
      gen_rst  <= 1'b1;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start_ok_s) begin
            state_r <= S_GEN_RST;
            words_r <= num_words;
            cnt_r   <= RST_LAST;
            gen_rst <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            aborted <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_GEN_RST: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= S_PRIME;
            gen_rst <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        // The generator presents its first word at the end of this cycle.
        S_PRIME: begin
          if (words_r != CNT_ZERO) begin
            state_r  <= S_RUN;
            cnt_r    <= words_r - CNT_ONE;
            tx_valid <= 1'b1;
          end else begin
            state_r <= S_DRAIN;
            cnt_r   <= LAT_LAST;
          end
        end
        S_RUN: begin
          if (cnt_r == CNT_ZERO) begin
            state_r  <= S_DRAIN;
            cnt_r    <= LAT_LAST;
            tx_valid <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        // Wait out the loopback latency so the last word gets compared.
        S_DRAIN: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          gen_rst  <= 1'b1;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Expected-data delay line matching the loopback latency; abort flushes it
  // so no stale word is compared after the test stops.
  always_ff @(posedge clk) begin
    if (!reset_n || abort_ok_s) begin
      dv_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        dd_r[i] <= {SIZE{1'b0}};
      end
    end else begin
      dv_r[0] <= tx_valid;
      dd_r[0] <= tx_data;
      for (int i = 1; i < LAT; i++) begin
        dv_r[i] <= dv_r[i-1];
        dd_r[i] <= dd_r[i-1];
      end
    end
  end

  assign exp_valid_s = dv_r[LAT-1];
  assign exp_data_s  = dd_r[LAT-1];

  // Next values of both error counters, clamped at the all-ones limit.
  always_comb begin
    diff_s     = rx_data ^ exp_data_s;
    bit_sum_s  = SW'(bit_errs) + SW'(popcount(diff_s));
    word_sum_s = SW'(word_errs) + SW'(|diff_s);
    if (bit_sum_s > SW'(CNT_MAX)) begin
      bit_next_s = CNT_MAX;
    end else begin
      bit_next_s = bit_sum_s[CW-1:0];
    end
    if (word_sum_s > SW'(CNT_MAX)) begin
      word_next_s = CNT_MAX;
    end else begin
      word_next_s = word_sum_s[CW-1:0];
    end
  end

  // Error counters: cleared by reset or an accepted start, frozen on abort.
  always_ff @(posedge clk) begin
    if (!reset_n || start_ok_s) begin
      bit_errs  <= CNT_ZERO;
      word_errs <= CNT_ZERO;
    end else if (exp_valid_s && !abort_ok_s) begin
      bit_errs  <= bit_next_s;
      word_errs <= word_next_s;
    end else begin
      bit_errs  <= bit_errs;
      word_errs <= word_errs;
    end
  end

endmodule
